// File: rtl/writeback_cycle_pkg.sv
// Shared definitions for the write-back stage: source-select encodings,
// FSM states and the datapath widths also used by decode and the pipeline registers.
package writeback_cycle_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int RD_W_DEF   = 4;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC  = 2'b10;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_MEM = 1'b1
    } wb_state_e;

endpackage

// File: rtl/writeback_cycle_select.sv
// Combinational 3-way write-back source select; the reserved code falls back to the ALU result.
module wb_select_mux
    import writeback_cycle_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [1:0]        wbsel,
    input  logic [DATA_W-1:0] aluout,
    input  logic [DATA_W-1:0] pcplus,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] sel_data
);

    always_comb begin
        sel_data = aluout;
        case (wbsel)
            WB_MEM:  sel_data = mem_rdata;
            WB_PC:   sel_data = pcplus;
            default: sel_data = aluout;
        endcase
    end

endmodule

// File: rtl/writeback_cycle.sv
// Final pipeline stage: commits the selected result to the register file, stalls on slow
// loads with a bounded wait, and counts retired instructions.
module writeback_cycle
    import writeback_cycle_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int RD_W     = RD_W_DEF,
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    output logic              ready,
    input  logic [RD_W-1:0]   rd_in,
    input  logic              regwrite_in,
    input  logic              memread_in,
    input  logic [1:0]        wbsel,
    input  logic [DATA_W-1:0] aluout,
    input  logic [DATA_W-1:0] pcplus,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              regwrite,
    output logic [RD_W-1:0]   rdout,
    output logic [DATA_W-1:0] writedata,
    output logic [CNT_W-1:0]  retired,
    output logic              err
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    wb_state_e         state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [RD_W-1:0]   hold_rd_q, hold_rd_d;
    logic              hold_regwrite_q, hold_regwrite_d;
    logic [1:0]        hold_wbsel_q, hold_wbsel_d;
    logic [DATA_W-1:0] hold_alu_q, hold_alu_d;
    logic [DATA_W-1:0] hold_pc_q, hold_pc_d;
    logic              regwrite_q, regwrite_d;
    logic [RD_W-1:0]   rdout_q, rdout_d;
    logic [DATA_W-1:0] writedata_q, writedata_d;
    logic [CNT_W-1:0]  retired_q, retired_d;
    logic              err_q, err_d;

    logic [DATA_W-1:0] live_data;
    logic [DATA_W-1:0] held_data;
    logic              accept;

    wb_select_mux #(.DATA_W(DATA_W)) u_live_mux (
        .wbsel     (wbsel),
        .aluout    (aluout),
        .pcplus    (pcplus),
        .mem_rdata (mem_rdata),
        .sel_data  (live_data)
    );

    wb_select_mux #(.DATA_W(DATA_W)) u_held_mux (
        .wbsel     (hold_wbsel_q),
        .aluout    (hold_alu_q),
        .pcplus    (hold_pc_q),
        .mem_rdata (mem_rdata),
        .sel_data  (held_data)
    );

    // ready depends on state only, so upstream never sees a combinational loop through us
    assign ready  = (state_q == IDLE);
    assign accept = valid_in && ready;

    always_comb begin
        state_d         = state_q;
        wait_d          = wait_q;
        hold_rd_d       = hold_rd_q;
        hold_regwrite_d = hold_regwrite_q;
        hold_wbsel_d    = hold_wbsel_q;
        hold_alu_d      = hold_alu_q;
        hold_pc_d       = hold_pc_q;
        regwrite_d      = 1'b0;
        rdout_d         = rdout_q;
        writedata_d     = writedata_q;
        retired_d       = retired_q;
        err_d           = err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (memread_in && !mem_ready) begin
                        hold_rd_d       = rd_in;
                        hold_regwrite_d = regwrite_in;
                        hold_wbsel_d    = wbsel;
                        hold_alu_d      = aluout;
                        hold_pc_d       = pcplus;
                        wait_d          = '0;
                        state_d         = WAIT_MEM;
                    end else begin
                        regwrite_d  = regwrite_in && (rd_in != '0);
                        rdout_d     = rd_in;
                        writedata_d = live_data;
                        retired_d   = retired_q + CNT_W'(1);
                    end
                end
            end
            WAIT_MEM: begin
                wait_d = wait_q + WAIT_W'(1);
                if (mem_ready) begin
                    regwrite_d  = hold_regwrite_q && (hold_rd_q != '0);
                    rdout_d     = hold_rd_q;
                    writedata_d = held_data;
                    retired_d   = retired_q + CNT_W'(1);
                    state_d     = IDLE;
                end else if (wait_d == WAIT_W'(MAX_WAIT)) begin
                    // abandoned load: no write, not counted as retired
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= IDLE;
            wait_q          <= '0;
            hold_rd_q       <= '0;
            hold_regwrite_q <= 1'b0;
            hold_wbsel_q    <= '0;
            hold_alu_q      <= '0;
            hold_pc_q       <= '0;
            regwrite_q      <= 1'b0;
            rdout_q         <= '0;
            writedata_q     <= '0;
            retired_q       <= '0;
            err_q           <= 1'b0;
        end else begin
            state_q         <= state_d;
            wait_q          <= wait_d;
            hold_rd_q       <= hold_rd_d;
            hold_regwrite_q <= hold_regwrite_d;
            hold_wbsel_q    <= hold_wbsel_d;
            hold_alu_q      <= hold_alu_d;
            hold_pc_q       <= hold_pc_d;
            regwrite_q      <= regwrite_d;
            rdout_q         <= rdout_d;
            writedata_q     <= writedata_d;
            retired_q       <= retired_d;
            err_q           <= err_d;
        end
    end

    assign regwrite  = regwrite_q;
    assign rdout     = rdout_q;
    assign writedata = writedata_q;
    assign retired   = retired_q;
    assign err       = err_q;

endmodule

// File: tb/tb_writeback_cycle.sv
// Scoreboard bench for writeback_cycle: expected register writes are queued as stimulus
// is driven and popped by a monitor whenever the DUT strobes regwrite.
module tb_writeback_cycle;

    logic        clk;
    logic        rst;
    logic        valid_in;
    logic        ready;
    logic [3:0]  rd_in;
    logic        regwrite_in;
    logic        memread_in;
    logic [1:0]  wbsel;
    logic [15:0] aluout;
    logic [15:0] pcplus;
    logic [15:0] mem_rdata;
    logic        mem_ready;
    logic        regwrite;
    logic [3:0]  rdout;
    logic [15:0] writedata;
    logic [15:0] retired;
    logic        err;

    typedef struct packed {
        logic [3:0]  rd;
        logic [15:0] data;
    } wb_exp_t;

    wb_exp_t     exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_retired = 16'h0000;

    writeback_cycle dut (
        .clk         (clk),
        .rst         (rst),
        .valid_in    (valid_in),
        .ready       (ready),
        .rd_in       (rd_in),
        .regwrite_in (regwrite_in),
        .memread_in  (memread_in),
        .wbsel       (wbsel),
        .aluout      (aluout),
        .pcplus      (pcplus),
        .mem_rdata   (mem_rdata),
        .mem_ready   (mem_ready),
        .regwrite    (regwrite),
        .rdout       (rdout),
        .writedata   (writedata),
        .retired     (retired),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every regwrite pulse must match the oldest expected write
    always @(negedge clk) begin
        if (rst === 1'b1 && regwrite === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL wb_unexpected: got write rd=%0d data=%h, required no write", rdout, writedata);
            end else begin
                wb_exp_t e;
                e = exp_q.pop_front();
                if (rdout !== e.rd || writedata !== e.data) begin
                    errors++;
                    $display("[TB] FAIL wb_write: got rd=%0d data=%h, required rd=%0d data=%h",
                             rdout, writedata, e.rd, e.data);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        valid_in    = 1'b0;
        rd_in       = 4'd0;
        regwrite_in = 1'b0;
        memread_in  = 1'b0;
        wbsel       = 2'b00;
        aluout      = 16'h0000;
        pcplus      = 16'h0000;
        mem_rdata   = 16'h0000;
        mem_ready   = 1'b0;
    endtask

    task automatic drive_alu(input logic [3:0] rd, input logic [1:0] sel, input logic we,
                             input logic [15:0] alu, input logic [15:0] pc);
        valid_in    = 1'b1;
        rd_in       = rd;
        regwrite_in = we;
        memread_in  = 1'b0;
        wbsel       = sel;
        aluout      = alu;
        pcplus      = pc;
        mem_ready   = 1'b0;
        if (we && rd != 4'd0) exp_q.push_back({rd, (sel == 2'b10) ? pc : alu});
        exp_retired = exp_retired + 16'd1;
    endtask

    task automatic check_retired(input string name);
        checks++;
        if (retired !== exp_retired) begin
            errors++;
            $display("[TB] FAIL %s: retired got %h, required %h", name, retired, exp_retired);
        end
    endtask

    task automatic test_reset();
        drive_idle();
        rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        checks++;
        if (ready !== 1'b1 || regwrite !== 1'b0 || rdout !== 4'd0 || writedata !== 16'h0 ||
            retired !== 16'h0 || err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_state: ready=%b regwrite=%b rdout=%0d wd=%h retired=%h err=%b, required 1 0 0 0000 0000 0",
                     ready, regwrite, rdout, writedata, retired, err);
        end
        step();
        step();
        rst = 1'b1;
        exp_retired = 16'h0000;
    endtask

    task automatic test_alu();
        drive_alu(4'd3, 2'b00, 1'b1, 16'h1234, 16'h0002);
        step();
        drive_idle();
        checks++;
        if (regwrite !== 1'b1 || rdout !== 4'd3 || writedata !== 16'h1234 || ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL alu_commit: regwrite=%b rdout=%0d wd=%h ready=%b, required 1 3 1234 1",
                     regwrite, rdout, writedata, ready);
        end
        check_retired("alu_retired");
    endtask

    task automatic test_load_ontime();
        valid_in    = 1'b1;
        rd_in       = 4'd5;
        regwrite_in = 1'b1;
        memread_in  = 1'b1;
        wbsel       = 2'b01;
        aluout      = 16'h0F00;
        mem_rdata   = 16'hBEEF;
        mem_ready   = 1'b1;
        exp_q.push_back({4'd5, 16'hBEEF});
        exp_retired = exp_retired + 16'd1;
        step();
        drive_idle();
        checks++;
        if (regwrite !== 1'b1 || rdout !== 4'd5 || writedata !== 16'hBEEF || ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL load_ontime: regwrite=%b rdout=%0d wd=%h ready=%b, required 1 5 beef 1",
                     regwrite, rdout, writedata, ready);
        end
        check_retired("load_ontime_retired");
    endtask

    task automatic test_load_latency();
        int low_cycles;
        valid_in    = 1'b1;
        rd_in       = 4'd7;
        regwrite_in = 1'b1;
        memread_in  = 1'b1;
        wbsel       = 2'b01;
        aluout      = 16'h5555;
        pcplus      = 16'h6666;
        mem_ready   = 1'b0;
        exp_q.push_back({4'd7, 16'h00AA});
        step();
        // Next instruction waits on the bus; it must be ignored until the stall ends
        drive_alu(4'd9, 2'b00, 1'b1, 16'h0999, 16'h0000);
        exp_retired = exp_retired + 16'd1;
        low_cycles = 0;
        for (int i = 0; i < 4; i++) begin
            if (ready === 1'b0) low_cycles++;
            checks++;
            if (regwrite !== 1'b0) begin
                errors++;
                $display("[TB] FAIL latency_no_early_write: cycle %0d regwrite=%b, required 0", i, regwrite);
            end
            if (i == 3) begin
                mem_ready = 1'b1;
                mem_rdata = 16'h00AA;
            end
            step();
        end
        mem_ready = 1'b0;
        checks++;
        if (low_cycles != 4 || ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL latency_stall: ready low %0d cycles, ready now %b, required 4 and 1", low_cycles, ready);
        end
        checks++;
        if (regwrite !== 1'b1 || rdout !== 4'd7 || writedata !== 16'h00AA) begin
            errors++;
            $display("[TB] FAIL latency_commit: regwrite=%b rdout=%0d wd=%h, required 1 7 00aa", regwrite, rdout, writedata);
        end
        exp_retired = exp_retired - 16'd1;
        check_retired("latency_retired");
        exp_retired = exp_retired + 16'd1;
        step();
        drive_idle();
        checks++;
        if (regwrite !== 1'b1 || rdout !== 4'd9 || writedata !== 16'h0999) begin
            errors++;
            $display("[TB] FAIL latency_next: regwrite=%b rdout=%0d wd=%h, required 1 9 0999", regwrite, rdout, writedata);
        end
        check_retired("latency_next_retired");
    endtask

    task automatic test_jal_rd0();
        drive_alu(4'd0, 2'b10, 1'b1, 16'h1111, 16'h0042);
        step();
        drive_idle();
        checks++;
        if (regwrite !== 1'b0) begin
            errors++;
            $display("[TB] FAIL jal_rd0: regwrite got %b, required 0", regwrite);
        end
        check_retired("jal_rd0_retired");
    endtask

    task automatic test_back_to_back();
        drive_alu(4'd1, 2'b00, 1'b1, 16'hA001, 16'h0000);
        step();
        drive_alu(4'd2, 2'b10, 1'b1, 16'hA002, 16'h0044);
        step();
        drive_alu(4'd3, 2'b11, 1'b1, 16'hA003, 16'h0046);
        step();
        drive_alu(4'd4, 2'b00, 1'b0, 16'hA004, 16'h0048);
        step();
        drive_alu(4'd15, 2'b00, 1'b1, 16'hFFFF, 16'h004A);
        step();
        drive_idle();
        checks++;
        if (ready !== 1'b1 || rdout !== 4'd15 || writedata !== 16'hFFFF) begin
            errors++;
            $display("[TB] FAIL b2b_last: ready=%b rdout=%0d wd=%h, required 1 15 ffff", ready, rdout, writedata);
        end
        check_retired("b2b_retired");
        step();
        checks++;
        if (regwrite !== 1'b0 || rdout !== 4'd15 || writedata !== 16'hFFFF) begin
            errors++;
            $display("[TB] FAIL b2b_hold: regwrite=%b rdout=%0d wd=%h, required 0 15 ffff", regwrite, rdout, writedata);
        end
    endtask

    task automatic test_timeout();
        int low_cycles;
        valid_in    = 1'b1;
        rd_in       = 4'd6;
        regwrite_in = 1'b1;
        memread_in  = 1'b1;
        wbsel       = 2'b01;
        aluout      = 16'h7777;
        mem_ready   = 1'b0;
        step();
        drive_idle();
        low_cycles = 0;
        while (ready !== 1'b1 && low_cycles < 40) begin
            low_cycles++;
            step();
        end
        checks++;
        if (low_cycles != 15) begin
            errors++;
            $display("[TB] FAIL timeout_wait: ready low %0d cycles, required 15", low_cycles);
        end
        checks++;
        if (err !== 1'b1 || regwrite !== 1'b0) begin
            errors++;
            $display("[TB] FAIL timeout_err: err=%b regwrite=%b, required 1 0", err, regwrite);
        end
        check_retired("timeout_retired");
        drive_alu(4'd2, 2'b00, 1'b1, 16'h2222, 16'h0000);
        step();
        drive_idle();
        checks++;
        if (regwrite !== 1'b1 || rdout !== 4'd2 || writedata !== 16'h2222 || err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL timeout_recover: regwrite=%b rdout=%0d wd=%h err=%b, required 1 2 2222 1",
                     regwrite, rdout, writedata, err);
        end
        check_retired("timeout_recover_retired");
    endtask

    task automatic test_wrap();
        int n;
        n = 16'hFFFF - exp_retired;
        for (int i = 0; i < n; i++) begin
            drive_alu(4'd1, 2'b00, 1'b0, 16'h0000, 16'h0000);
            step();
        end
        drive_idle();
        check_retired("wrap_full");
        drive_alu(4'd4, 2'b00, 1'b1, 16'hABCD, 16'h0000);
        step();
        drive_idle();
        checks++;
        if (retired !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL wrap_zero: retired got %h, required 0000", retired);
        end
    endtask

    task automatic test_reset_mid_wait();
        valid_in    = 1'b1;
        rd_in       = 4'd8;
        regwrite_in = 1'b1;
        memread_in  = 1'b1;
        wbsel       = 2'b01;
        mem_ready   = 1'b0;
        step();
        drive_idle();
        step();
        #2 rst = 1'b0;
        #1;
        checks++;
        if (ready !== 1'b1 || regwrite !== 1'b0 || rdout !== 4'd0 || writedata !== 16'h0 ||
            retired !== 16'h0 || err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_async: ready=%b regwrite=%b rdout=%0d wd=%h retired=%h err=%b, required 1 0 0 0000 0000 0",
                     ready, regwrite, rdout, writedata, retired, err);
        end
        exp_retired = 16'h0000;
        step();
        rst       = 1'b1;
        mem_ready = 1'b1;
        mem_rdata = 16'hDEAD;
        step();
        mem_ready = 1'b0;
        checks++;
        if (regwrite !== 1'b0 || rdout !== 4'd0 || writedata !== 16'h0) begin
            errors++;
            $display("[TB] FAIL reset_late_data: regwrite=%b rdout=%0d wd=%h, required 0 0 0000", regwrite, rdout, writedata);
        end
        check_retired("reset_late_retired");
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_ontime();
        test_load_latency();
        test_jal_rd0();
        test_back_to_back();
        test_timeout();
        test_wrap();
        test_reset_mid_wait();
        step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: %0d expected writes never seen, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
